// File: rtl/clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_gen_pkg : shared types, defaults and half-period helper for clock gen
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clk_gen_pkg;

  localparam int unsigned DEF_DIV_W     = 32;
  localparam int unsigned DEF_BASE_HALF = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PARK = 2'd2
  } state_e;

  // Half-period length base >> sh, never below one cycle.
  function automatic logic [63:0] half_len(input logic [63:0] base,
                                           input int unsigned sh,
                                           input int unsigned div_w);
    logic [63:0] l;
    l = 64'd1;
    if ((sh < div_w) && (sh < 32'd64)) begin
      l = base >> sh;
      if (l == 64'd0) l = 64'd1;
    end
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gen_channel.sv
// ---------------------------------------------------------------------------
// clk_gen_channel : one divided-clock / tick channel with glitch-free rate change
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W     = DEF_DIV_W,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned BASE_HALF = DEF_BASE_HALF,
  parameter logic        IDLE_LVL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic [SEL_W-1:0] sel,
  output logic             sclk,
  output logic             tick,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   count_q, count_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sclk_q, sclk_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;

  logic [DIV_W-1:0]   len;
  logic [DIV_W-1:0]   last;
  logic               at_last;

  always_comb begin
    len     = DIV_W'(half_len(64'(BASE_HALF), 32'(sel_q), DIV_W));
    last    = len - DIV_W'(1);
    // >= rather than == so a shorter L after reload still terminates
    at_last = (count_q >= last);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sel_d   = sel_q;
    sclk_d  = sclk_q;
    tick_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        sclk_d  = IDLE_LVL;
        sel_d   = sel;
        if (en) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!hold && at_last) begin
          sclk_d  = ~sclk_q;
          count_d = '0;
          sel_d   = sel;
          tick_d  = (sclk_q != IDLE_LVL);
          if (!en) state_d = (sclk_d == IDLE_LVL) ? ST_IDLE : ST_PARK;
        end else begin
          if (!hold) count_d = count_q + DIV_W'(1);
          if (!en) begin
            if (sclk_q == IDLE_LVL) begin
              state_d = ST_IDLE;
              count_d = '0;
            end else begin
              state_d = ST_PARK;
            end
          end
        end
      end

      ST_PARK: begin
        if (!hold) begin
          if (at_last) begin
            sclk_d  = ~sclk_q;
            count_d = '0;
            tick_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            count_d = count_q + DIV_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sel_q   <= '0;
      sclk_q  <= IDLE_LVL;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk = sclk_q;
  assign tick = tick_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/programmable_clock_gen.sv
// ---------------------------------------------------------------------------
// programmable_clock_gen : multi-channel programmable clock and tick generator
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module programmable_clock_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV_W     = DEF_DIV_W,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned BASE_HALF = DEF_BASE_HALF,
  parameter logic        IDLE_LVL  = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS-1:0]       EN,
  input  logic                      HOLD,
  input  logic [CHANNELS*SEL_W-1:0] SEL,
  output logic [CHANNELS-1:0]       SCLK,
  output logic [CHANNELS-1:0]       TICK,
  output logic [CHANNELS-1:0]       BUSY
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clk_gen_channel #(
      .DIV_W     (DIV_W),
      .SEL_W     (SEL_W),
      .BASE_HALF (BASE_HALF),
      .IDLE_LVL  (IDLE_LVL)
    ) u_ch (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (EN[i]),
      .hold  (HOLD),
      .sel   (SEL[i*SEL_W +: SEL_W]),
      .sclk  (SCLK[i]),
      .tick  (TICK[i]),
      .busy  (BUSY[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_programmable_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_programmable_clock_gen : scoreboard bench, BASE_HALF=8, two channels
// Revision                  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_programmable_clock_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic       hold;
  logic [5:0] sel;
  logic [1:0] sclk;
  logic [1:0] tick;
  logic [1:0] busy;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] sclk;
    logic [1:0] tick;
    logic [1:0] busy;
  } exp_t;

  exp_t sb[$];

  programmable_clock_gen #(
    .CHANNELS  (2),
    .DIV_W     (32),
    .SEL_W     (3),
    .BASE_HALF (8),
    .IDLE_LVL  (1'b1)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .HOLD  (hold),
    .SEL   (sel),
    .SCLK  (sclk),
    .TICK  (tick),
    .BUSY  (busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] s, input logic [1:0] t,
                      input logic [1:0] b);
    exp_t e;
    e.cyc  = c;
    e.sclk = s;
    e.tick = t;
    e.busy = b;
    sb.push_back(e);
  endtask

  // Returns just after edge n; inputs set now are sampled at edge n+1.
  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : p_mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL missed_cyc%0d: monitor reached cycle %0d first", e.cyc, cyc);
      end else if (sclk !== e.sclk || tick !== e.tick || busy !== e.busy) begin
        n_fail++;
        $display("FAIL cyc%0d: got sclk=%b tick=%b busy=%b, want sclk=%b tick=%b busy=%b",
                 cyc, sclk, tick, busy, e.sclk, e.tick, e.busy);
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 2'b00;
    hold  = 1'b0;
    sel   = 6'b000_000;

    // Reset state
    push(2, 2'b11, 2'b00, 2'b00);
    at_edge(2);
    rst_n = 1'b1;

    // Basic divide, ch0 SEL=0: start at edge 5, toggles every 8 edges
    push(5,  2'b11, 2'b00, 2'b01);
    push(12, 2'b11, 2'b00, 2'b01);
    push(13, 2'b10, 2'b00, 2'b01);
    push(20, 2'b10, 2'b00, 2'b01);
    push(21, 2'b11, 2'b01, 2'b01);
    push(22, 2'b11, 2'b00, 2'b01);
    push(37, 2'b11, 2'b01, 2'b01);
    at_edge(4);
    en = 2'b01;

    // Reconfig SEL 0->2 mid high half: half ending at 45 stays 8, then L=2
    at_edge(40);
    sel = 6'b000_010;
    push(44, 2'b11, 2'b00, 2'b01);
    push(45, 2'b10, 2'b00, 2'b01);
    push(46, 2'b10, 2'b00, 2'b01);
    push(47, 2'b11, 2'b01, 2'b01);
    push(48, 2'b11, 2'b00, 2'b01);
    push(49, 2'b10, 2'b00, 2'b01);
    push(51, 2'b11, 2'b01, 2'b01);

    // Park: L=8 low half starts at 53, EN drop sampled at 56, return high at 61
    at_edge(52);
    sel = 6'b000_000;
    push(53, 2'b10, 2'b00, 2'b01);
    push(56, 2'b10, 2'b00, 2'b01);
    push(60, 2'b10, 2'b00, 2'b01);
    push(61, 2'b11, 2'b01, 2'b00);
    push(62, 2'b11, 2'b00, 2'b00);
    at_edge(55);
    en = 2'b00;

    // Clamp: SEL=5 gives L=1; EN drop on a toggle into low goes via PARK
    at_edge(64);
    sel = 6'b000_101;
    en  = 2'b01;
    push(65, 2'b11, 2'b00, 2'b01);
    push(66, 2'b10, 2'b00, 2'b01);
    push(67, 2'b11, 2'b01, 2'b01);
    push(68, 2'b10, 2'b00, 2'b01);
    push(69, 2'b11, 2'b01, 2'b01);
    push(70, 2'b10, 2'b00, 2'b01);
    push(71, 2'b11, 2'b01, 2'b00);
    at_edge(69);
    en = 2'b00;

    // Hold for edges 76..85: first toggle moves from 81 to 91
    at_edge(72);
    sel = 6'b000_000;
    en  = 2'b01;
    push(81, 2'b11, 2'b00, 2'b01);
    push(85, 2'b11, 2'b00, 2'b01);
    push(90, 2'b11, 2'b00, 2'b01);
    push(91, 2'b10, 2'b00, 2'b01);
    at_edge(75);
    hold = 1'b1;
    at_edge(85);
    hold = 1'b0;

    // Mid-run reset while SCLK is low
    at_edge(93);
    rst_n = 1'b0;
    push(94, 2'b11, 2'b00, 2'b00);
    push(96, 2'b11, 2'b00, 2'b00);
    at_edge(94);
    rst_n = 1'b1;
    en    = 2'b00;

    // Two channels: ch1 SEL=1 (L=4), ch0 SEL=0 (L=8), both start at edge 98
    at_edge(97);
    sel = 6'b001_000;
    en  = 2'b11;
    push(98,  2'b11, 2'b00, 2'b11);
    push(102, 2'b01, 2'b00, 2'b11);
    push(106, 2'b10, 2'b10, 2'b11);
    push(110, 2'b00, 2'b00, 2'b11);
    push(114, 2'b11, 2'b11, 2'b11);
    push(118, 2'b01, 2'b00, 2'b11);
    push(122, 2'b10, 2'b10, 2'b11);
    push(130, 2'b11, 2'b11, 2'b11);

    at_edge(132);
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL unchecked_cyc%0d: expectation never compared", e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/programmable_clock_gen.md
# programmable_clock_gen

Multi-channel programmable clock and tick generator. Each channel derives a divided square wave and a one-cycle tick strobe from the system clock. The half-period is selected per channel as a power-of-two fraction of a base count. Rate changes are applied only at half-period boundaries, so outputs never glitch. A disabled channel finishes its active half-period before parking at the idle level. The block sits between the board clock and slow consumers: display scanning, LED blinkers and debouncers.

## Interface

- CHANNELS, 2, number of independent output channels
- DIV_W, 32, counter width; must hold BASE_HALF-1
- SEL_W, 3, width of each channel's rate-select field
- BASE_HALF, 50_000_000, half-period in CLK cycles at SEL=0
- IDLE_LVL, 1'b1, SCLK level at reset and when parked

Ports:

- CLK  input  1  system clock; all logic on rising edge
- RST_N  input  1  synchronous, active-low reset
- EN  input  CHANNELS  per-channel enable
- HOLD  input  1  global pause; freezes all counters, outputs hold their level
- SEL  input  CHANNELS*SEL_W  per-channel rate select; channel i uses SEL[i*SEL_W +: SEL_W]
- SCLK  output  CHANNELS  divided clock outputs, registered
- TICK  output  CHANNELS  one-cycle strobe, registered
- BUSY  output  CHANNELS  channel is in RUN or PARK

## Operation

- Half-period length: L = BASE_HALF >> sel_active.
  - If L is 0, it is clamped to 1.
  - Shift amounts of DIV_W or more give L=1.
- Per-channel state machine:
  - IDLE -> RUN when EN=1. The counter is cleared and SEL is latched into sel_active.
  - RUN -> RUN at count==L-1 (and HOLD=0): SCLK toggles, count clears, sel_active reloads from SEL.
  - RUN -> PARK when EN=0 and SCLK!=IDLE_LVL. The channel finishes the current half-period.
  - RUN -> IDLE when EN=0 and SCLK==IDLE_LVL. This takes effect the same cycle, with no toggle.
  - PARK -> IDLE at count==L-1. SCLK toggles back to IDLE_LVL and no reload occurs.
  - EN re-asserted during PARK is ignored until IDLE is reached; the channel then restarts on the next cycle.
- In IDLE:
  - count=0, SCLK=IDLE_LVL.
  - sel_active tracks SEL every cycle.
- TICK[i] is 1 for exactly one cycle, coincident with each SCLK[i] transition from !IDLE_LVL to IDLE_LVL (the completion of a full period). This includes the final toggle into IDLE.
- HOLD=1 has these effects:
  - No count increment, no toggle, no TICK, no sel_active reload.
  - State transitions caused by EN still occur. A RUN->IDLE exit happens only when SCLK is already at IDLE_LVL.
- Arithmetic:
  - count is DIV_W bits, unsigned.
  - The compare is count >= L-1, which guards against a shrinking L after a reload.
  - count never wraps.

## Timing

- Reset values (RST_N=0 at a rising edge):
  - SCLK = {CHANNELS{IDLE_LVL}}
  - TICK = 0, BUSY = 0
  - state = IDLE, count = 0, sel_active = 0
- Reset mid-operation takes effect on the next edge, with no completion of the current half-period.
- From EN rising (sampled at edge k):
  - BUSY=1 after edge k.
  - The first SCLK toggle follows edge k+L.
- In steady state, SCLK period = 2L cycles. Each level lasts exactly L cycles.
- SEL change: takes effect for the half-period beginning at the next toggle. The current half-period keeps its old L.
- Simultaneous events:
  - EN fall and count==L-1 in RUN: the toggle occurs. The next state is IDLE if the new level is IDLE_LVL, else PARK.
  - HOLD=1 and count==L-1: the toggle is deferred until HOLD=0.
- Channels are fully independent. No phase relationship is guaranteed except that equal SEL values and simultaneous EN give identical outputs.

## Structure

- Package clk_gen_pkg contains:
  - the state enum (ST_IDLE, ST_RUN, ST_PARK)
  - a half_len(base, sel) function implementing shift and clamp
  - default constants for BASE_HALF and DIV_W
- Sub-module clk_gen_channel holds one counter, state register, sel_active and output flops. The top generates CHANNELS instances and slices SEL.

## Test plan

Benches use BASE_HALF=8.

- Basic divide: EN[0]=1, SEL=0 -> SCLK[0] is low 8 cycles, then high 8; TICK pulses every 16 cycles on the rising edge.
- Reconfiguration: switch SEL 0->2 mid-half-period -> the current half stays 8 cycles, following halves are 2 cycles; no pulse shorter than 2.
- Clamp: SEL=5 (8>>5=0) -> L=1, SCLK toggles every cycle, period 2.
- Park: drop EN at cycle 3 of a low half (IDLE_LVL=1) -> state PARK; SCLK returns high 5 cycles later with TICK=1; BUSY=0 thereafter.
- Hold and reset: HOLD=1 for 10 cycles mid-count -> SCLK frozen and no TICK; the remaining count resumes afterward. RST_N=0 mid-run -> next edge SCLK=1, BUSY=0, TICK=0.
- Two channels: SEL={1,0}, both EN -> ch1 period 8, ch0 period 16; rising edges align every 16 cycles.
